// File: rtl/psk_code_xmit.sv
// Code-shift PSK transmitter: each 3-bit symbol selects a cyclic rotation of a 6-chip
// base code, sent REPEAT times on a chip grid that free-runs from reset.
module psk_code_xmit #(
  parameter logic [5:0] CODE     = 6'b000111,
  parameter int         REPEAT   = 8,
  parameter int         CHIP_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sym,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       sig,
  output logic       sym_stb,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CHIP_DIV - 1);
  localparam logic [7:0] REP_LAST = 8'(REPEAT - 1);

  state_t     state_r;
  logic [7:0] div_cnt_r;
  logic [7:0] rep_cnt_r;
  logic [2:0] chip_idx_r;
  logic [2:0] cur_r;
  logic       sig_r;
  logic       stb_r;
  logic       busy_r;

  logic       chip_tick_s;
  logic       period_start_s;
  logic       last_clk_s;
  logic       accept_s;
  logic [2:0] chip_next_s;

  // Chip of phase 'phase' at grid index 'idx'; phases 6 and 7 are silent.
  function automatic logic chip_bit(input logic [2:0] phase, input logic [2:0] idx);
    logic [3:0] sum;
    logic [2:0] n;
    sum = {1'b0, phase} + {1'b0, idx};
    n   = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
    if (phase > 3'd5) begin
      return 1'b0;
    end else begin
      return CODE[3'd5 - n];
    end
  endfunction

  // Chip-grid timing decode and handshake ready derived from registered state.
  always_comb begin
    chip_tick_s = (div_cnt_r == DIV_LAST);
    if (!chip_tick_s) begin
      chip_next_s = chip_idx_r;
    end else if (chip_idx_r == 3'd5) begin
      chip_next_s = 3'd0;
    end else begin
      chip_next_s = chip_idx_r + 3'd1;
    end
    period_start_s = chip_tick_s && (chip_idx_r == 3'd5);
    last_clk_s     = (state_r == SEND) && period_start_s && (rep_cnt_r == REP_LAST);
    sym_ready      = !rst && ((state_r == IDLE) || last_clk_s);
    accept_s       = sym_valid && sym_ready;
  end

  // Free-running chip grid; never stalls so period boundaries stay tied to reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r  <= 8'd0;
      chip_idx_r <= 3'd0;
    end else begin
      div_cnt_r  <= chip_tick_s ? 8'd0 : div_cnt_r + 8'd1;
      chip_idx_r <= chip_next_s;
    end
  end

  // Symbol FSM with registered chip, strobe and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cur_r     <= 3'd0;
      rep_cnt_r <= 8'd0;
      sig_r     <= 1'b0;
      stb_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      stb_r <= 1'b0;
      case (state_r)
        IDLE: begin
          sig_r <= 1'b0;
          if (accept_s) begin
            cur_r  <= sym;
            busy_r <= 1'b1;
            // An accept on the last clock of a period starts sending immediately.
            if (period_start_s) begin
              state_r   <= SEND;
              rep_cnt_r <= 8'd0;
              stb_r     <= 1'b1;
              sig_r     <= chip_bit(sym, 3'd0);
            end else begin
              state_r <= WAIT;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        WAIT: begin
          if (period_start_s) begin
            state_r   <= SEND;
            rep_cnt_r <= 8'd0;
            stb_r     <= 1'b1;
            sig_r     <= chip_bit(cur_r, 3'd0);
          end else begin
            sig_r <= 1'b0;
          end
        end
        SEND: begin
          if (!period_start_s) begin
            sig_r <= chip_bit(cur_r, chip_next_s);
          end else if (rep_cnt_r != REP_LAST) begin
            rep_cnt_r <= rep_cnt_r + 8'd1;
            sig_r     <= chip_bit(cur_r, 3'd0);
          end else if (accept_s) begin
            cur_r     <= sym;
            rep_cnt_r <= 8'd0;
            stb_r     <= 1'b1;
            sig_r     <= chip_bit(sym, 3'd0);
          end else begin
            state_r <= IDLE;
            sig_r   <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          sig_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign sig     = sig_r;
  assign sym_stb = stb_r;
  assign busy    = busy_r;

endmodule

// File: doc/psk_code_xmit.md
# psk_code_xmit

Code-shift PSK transmitter for the DSP PSK link. It accepts 3-bit symbols over a valid/ready handshake and emits a 1-bit chip stream. Each symbol is the 6-chip base code cyclically rotated by the symbol value and repeated REPEAT times. Its chip index free-runs from reset, so a receiver correlator bank started from the same reset sees phase p as a match on correlator p.

## Interface
Parameters:
- CODE, 6'b000111: base code, read MSB-first (chip index 0 = CODE[5]); same code the receiver rotates.
- REPEAT, 8: code periods per symbol (1..255).
- CHIP_DIV, 1: clocks per chip (1..255); 1 matches the receiver's one-chip-per-clock rotation.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- sym, input, 3: symbol, i.e. the phase to transmit. Values 0..5 select a phase; 6 and 7 select a silent period.
- sym_valid, input, 1: sym is valid.
- sym_ready, output, 1: the block can accept a symbol this cycle.
- sig, output, 1: registered chip output.
- sym_stb, output, 1: one-clock pulse on the first clock of each transmitted symbol.
- busy, output, 1: high in WAIT or SEND.

## Operation
- Free-running counters, cleared by rst:
  - div_cnt: 0..CHIP_DIV-1.
  - chip_idx: 0..5; advances when div_cnt wraps, and wraps 5→0.
  - chip_idx never stalls. Code-period boundaries are fixed relative to reset.
- Chip value for phase p at chip_idx k: code bit (p+k) mod 6, where code bit n = CODE[5-n].
  - p=0 → 000111.
  - p=2 → 011100.
  - p=3 → 111000.
- Silent symbol (sym ≥ 6): sig=0 for the full symbol duration; sym_stb still pulses.
- FSM:
  - IDLE: sig=0, sym_ready=1. On accept, latch sym into cur and go to WAIT.
  - WAIT: sym_ready=0. Hold until the clock that starts chip 0 (chip_idx wraps 5→0 with div_cnt=0), then enter SEND, load rep_cnt=0 and pulse sym_stb.
  - SEND: sig=chip(cur, chip_idx). rep_cnt increments each time chip_idx wraps. The last chip is chip_idx=5 with rep_cnt=REPEAT-1. sym_ready=1 only on the final clock of the last chip.
    - Accept on that clock: latch the new sym, stay in SEND, reset rep_cnt, and pulse sym_stb on the next clock. Symbols are back-to-back with no gap.
    - No accept: go to IDLE and sig=0 from the next clock.
- rep_cnt is 8 bits.
- Handshake rules:
  - Transfer occurs on a clock with sym_valid & sym_ready.
  - sym_ready does not depend combinationally on sym_valid.
  - sym is ignored when no transfer occurs.

## Timing
- Reset values: sig=0, sym_stb=0, busy=0, sym_ready=0 while rst is asserted, state=IDLE, chip_idx=0, div_cnt=0.
- sym_ready=1 on the first clock after rst deasserts.
- sig, sym_stb, busy and chip_idx update on the same edge. A chip is visible on sig during the same clocks that chip_idx holds its index.
- Accept-to-first-chip latency, with CHIP_DIV=1: the number of clocks until chip_idx next returns to 0, i.e. 1..6 clocks.
  - Example: an accept while chip_idx=5 gives the first chip on the next clock.
  - An accept while chip_idx=0 waits 6 clocks, because the next period is used.
- Symbol duration: exactly 6·REPEAT·CHIP_DIV clocks of sig.
- Back-to-back symbols are contiguous. sym_stb pulses are spaced exactly 6·REPEAT·CHIP_DIV clocks apart.
- rst in any state aborts immediately:
  - The current symbol is dropped and any pending latch is lost.
  - sig=0 on the next clock.
  - No partial sym_stb is emitted.
- sym_valid asserted while in WAIT or in SEND before the last chip: no transfer; the source must hold sym.

## Test plan
- Reset then idle: rst 3 clocks, sym_valid=0 → sig=0, busy=0, sym_stb=0; sym_ready=0 during rst and 1 afterwards.
- Single symbol: REPEAT=2, CHIP_DIV=1; present sym=2 at chip_idx=3 → 2 clocks of WAIT, then sym_stb pulses. sig=011100011100, then 0; busy low again after 12 chips.
- Back-to-back: sym=0 then sym=3 (sym_valid held), REPEAT=1 → sig=000111111000 contiguous; sym_stb pulses 6 clocks apart; sym_ready high only on the last clock of each symbol.
- Silent symbol and CHIP_DIV: CHIP_DIV=3, REPEAT=1, sym=7 → sig=0 for 18 clocks, sym_stb pulses once, busy high for 18 clocks.
- Reset mid-symbol: rst asserted on the 4th chip of sym=3 → sig=0 the next clock, IDLE, chip_idx=0; a following sym=0 still transmits 000111 aligned to chip 0.
- Loopback: connect sig to the receiver dispatcher (shared rst); send each of sym=0..5 with REPEAT=8 → the receiver value has bit p set for symbol p.
